// File: rtl/fir_coef_commit.sv
// Debounced, frame-aligned commit of the b22/b23 FIR coefficient pair.
// A new register word must hold steady for SETTLE_CYCLES cycles, then it is applied on the next sync_in.
module fir_coef_commit #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] reg_word,
    input  logic        sync_in,
    output logic [15:0] coef_b22,
    output logic [15:0] coef_b23,
    output logic        coef_update,
    output logic        coef_pending,
    output logic [15:0] update_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PENDING
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [31:0] word_q;
    logic [31:0] cand_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] active_word;

    assign active_word = {coef_b22, coef_b23};

    // word_q decouples the FSM from a register word that may be mid-transition.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg    <= IDLE;
            word_q       <= '0;
            cand_reg     <= '0;
            cnt_reg      <= '0;
            coef_b22     <= '0;
            coef_b23     <= '0;
            coef_update  <= 1'b0;
            coef_pending <= 1'b0;
            update_count <= '0;
        end else begin
            word_q      <= reg_word;
            coef_update <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (word_q != active_word) begin
                        cand_reg  <= word_q;
                        cnt_reg   <= '0;
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (word_q != cand_reg) begin
                        cand_reg <= word_q;
                        cnt_reg  <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        // A word that drifted and came back to the active value needs no commit.
                        if (cand_reg != active_word) begin
                            state_reg    <= PENDING;
                            coef_pending <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                PENDING: begin
                    if (word_q != cand_reg) begin
                        cand_reg     <= word_q;
                        cnt_reg      <= '0;
                        state_reg    <= SETTLE;
                        coef_pending <= 1'b0;
                    end else if (sync_in) begin
                        coef_b22     <= cand_reg[31:16];
                        coef_b23     <= cand_reg[15:0];
                        coef_update  <= 1'b1;
                        update_count <= update_count + 16'd1;
                        state_reg    <= IDLE;
                        coef_pending <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    coef_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_commit.sv
// Directed and randomized checks of fir_coef_commit against a run-length reference model.
module tb_fir_coef_commit;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] reg_word = '0;
    logic        sync_in = 1'b0;
    logic [15:0] coef_b22, coef_b23, update_count;
    logic        coef_update, coef_pending;

    logic [31:0] w_word = '0;
    logic        w_sync = 1'b0;
    logic [15:0] w_b22, w_b23, w_count;
    logic        w_upd, w_pend;

    int errors = 0;
    int checks = 0;
    string scen = "reset";

    // Reference model: pending means word_q has held one non-active value for S+1 samples.
    logic [31:0] m_wq, m_run_val, m_active;
    int          m_run;
    logic        m_pend, m_upd;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    fir_coef_commit #(.SETTLE_CYCLES(S)) u_dut (
        .user_clk(clk), .user_rst_n(rst_n), .reg_word(reg_word), .sync_in(sync_in),
        .coef_b22(coef_b22), .coef_b23(coef_b23), .coef_update(coef_update),
        .coef_pending(coef_pending), .update_count(update_count)
    );

    fir_coef_commit #(.SETTLE_CYCLES(1)) u_wrap (
        .user_clk(clk), .user_rst_n(rst_n), .reg_word(w_word), .sync_in(w_sync),
        .coef_b22(w_b22), .coef_b23(w_b23), .coef_update(w_upd),
        .coef_pending(w_pend), .update_count(w_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed=%h expected=%h", scen, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wq = '0; m_run_val = '0; m_active = '0; m_run = 0;
        m_pend = 1'b0; m_upd = 1'b0; m_cnt = '0;
    endtask

    task automatic model_edge(input logic [31:0] w, input logic s);
        logic [31:0] smp;
        logic        commit;
        smp    = m_wq;
        commit = m_pend && s && (smp == m_run_val);
        if (smp == m_run_val) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run_val = smp;
            m_run     = 1;
        end
        m_upd = commit;
        if (commit) begin
            m_active = smp;
            m_cnt++;
        end
        m_pend = (m_run >= S + 1) && (m_run_val != m_active);
        m_wq   = w;
    endtask

    task automatic check_all();
        chk("b22", 32'(coef_b22), 32'(m_active[31:16]));
        chk("b23", 32'(coef_b23), 32'(m_active[15:0]));
        chk("update", 32'(coef_update), 32'(m_upd));
        chk("pending", 32'(coef_pending), 32'(m_pend));
        chk("count", 32'(update_count), 32'(m_cnt));
    endtask

    // Inputs change at a negedge, model advances at the posedge, outputs sampled at the next negedge.
    task automatic step(input logic [31:0] w, input logic s);
        reg_word = w;
        sync_in  = s;
        @(posedge clk);
        model_edge(w, s);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) step(w, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_b22", 32'(coef_b22), 32'h0);
        chk("rst_b23", 32'(coef_b23), 32'h0);
        chk("rst_update", 32'(coef_update), 32'h0);
        chk("rst_pending", 32'(coef_pending), 32'h0);
        chk("rst_count", 32'(update_count), 32'h0);
        chk("rst_wrap_count", 32'(w_count), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pool [4];
        logic [31:0] cur;
        logic [15:0] cnt_before;
        int          pulses;
        pool[0] = 32'h0000_0000; pool[1] = 32'hCAFE_F00D;
        pool[2] = 32'h5A5A_A5A5; pool[3] = 32'h0000_FFFF;

        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        scen = "basic";
        hold(32'h1234_ABCD, 5);
        chk("not_pending_e5", 32'(coef_pending), 32'h0);
        step(32'h1234_ABCD, 1'b0);
        chk("pending_e6", 32'(coef_pending), 32'h1);
        hold(32'h1234_ABCD, 3);
        step(32'h1234_ABCD, 1'b1);
        chk("b22_val", 32'(coef_b22), 32'h1234);
        chk("b23_val", 32'(coef_b23), 32'hABCD);
        chk("pulse", 32'(coef_update), 32'h1);
        chk("count1", 32'(update_count), 32'h1);
        step(32'h1234_ABCD, 1'b0);
        chk("pulse_end", 32'(coef_update), 32'h0);

        scen = "glitch";
        hold(32'h1111_2222, 4);
        hold(32'h3333_4444, 7);
        step(32'h3333_4444, 1'b1);
        chk("b22_val", 32'(coef_b22), 32'h3333);
        chk("b23_val", 32'(coef_b23), 32'h4444);
        hold(32'h3333_4444, 2);

        scen = "chg_pending";
        hold(32'hAAAA_5555, 8);
        chk("is_pending", 32'(coef_pending), 32'h1);
        step(32'h0F0F_0F0F, 1'b0);
        step(32'h0F0F_0F0F, 1'b1);
        chk("no_commit", 32'(coef_update), 32'h0);
        chk("kept_b22", 32'(coef_b22), 32'h3333);
        hold(32'h0F0F_0F0F, 6);
        step(32'h0F0F_0F0F, 1'b1);
        chk("b22_val", 32'(coef_b22), 32'h0F0F);
        chk("b23_val", 32'(coef_b23), 32'h0F0F);

        scen = "revert";
        hold(32'h1234_5678, 7);
        step(32'h1234_5678, 1'b1);
        cnt_before = update_count;
        hold(32'hDEAD_BEEF, 2);
        hold(32'h1234_5678, 10);
        chk("count_same", 32'(update_count), 32'(cnt_before));
        chk("b22_same", 32'(coef_b22), 32'h1234);

        scen = "sync_idle";
        step(32'h1234_5678, 1'b1);
        step(32'h1234_5678, 1'b1);
        hold(32'h7777_8888, 5);
        step(32'h7777_8888, 1'b1);
        chk("no_commit_completion", 32'(coef_update), 32'h0);
        chk("pending_completion", 32'(coef_pending), 32'h1);
        step(32'h7777_8888, 1'b0);
        step(32'h7777_8888, 1'b1);
        chk("commit_next", 32'(coef_update), 32'h1);

        scen = "rst_pending";
        hold(32'h4242_2424, 7);
        chk("is_pending", 32'(coef_pending), 32'h1);
        do_reset();
        hold(32'h4242_2424, 7);
        step(32'h4242_2424, 1'b1);
        chk("recommit_b22", 32'(coef_b22), 32'h4242);

        scen = "random";
        cur = 32'h4242_2424;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) cur = pool[$urandom_range(0, 3)];
            step(cur, ($urandom_range(0, 3) == 0));
        end

        scen = "wrap";
        reg_word = '0;
        sync_in  = 1'b0;
        do_reset();
        w_sync = 1'b1;
        pulses = 0;
        for (int i = 0; i < 65535; i++) begin
            w_word = i[0] ? 32'h0003_0004 : 32'h0001_0002;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (w_upd) pulses++;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (w_upd) pulses++;
        end
        chk("pulses", 32'(pulses), 32'd65535);
        chk("count_ffff", 32'(w_count), 32'h0000_FFFF);
        chk("b22_last", 32'(w_b22), 32'h0001);
        w_word = 32'h0003_0004;
        repeat (5) @(negedge clk);
        chk("count_wrapped", 32'(w_count), 32'h0);
        chk("b23_wrapped", 32'(w_b23), 32'h0004);
        w_sync = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
